// File: rtl/sha1_pkg.sv
// Shared types and constants for the SHA-1 block sequencer and its benches.
// Round boundaries are in core round numbering; IV words are the standard SHA-1 initial hash.
package sha1_pkg;

  typedef enum logic [1:0] {
    LOAD,
    RUN,
    DONE
  } state_t;

  localparam int DEF_N_WORDS    = 16;
  localparam int DEF_OUT_BASE   = 80;
  localparam int DEF_IDLE_ROUND = 127;

  localparam int W_LAST      = 15;
  localparam int CHAIN_FIRST = 11;
  localparam int CHAIN_LAST  = 15;

  localparam int ROUND_W  = 7;
  localparam int STEP_W   = 5;
  localparam int WORD_W   = 32;
  localparam int DIGEST_W = 160;

  localparam logic [31:0] IV_H0 = 32'h67452301;
  localparam logic [31:0] IV_H1 = 32'hEFCDAB89;
  localparam logic [31:0] IV_H2 = 32'h98BADCFE;
  localparam logic [31:0] IV_H3 = 32'h10325476;
  localparam logic [31:0] IV_H4 = 32'hC3D2E1F0;
  localparam logic [159:0] IV   = {IV_H0, IV_H1, IV_H2, IV_H3, IV_H4};

endpackage

// File: rtl/sha1_sequencer_if.sv
// Host-side block input and digest output handshakes of the SHA-1 sequencer.
// master = HMAC controller side, slave = sequencer side.
interface sha1_sequencer_if;
  import sha1_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [WORD_W-1:0]   in_data;
  logic                in_first;
  logic                out_valid;
  logic                out_ready;
  logic [DIGEST_W-1:0] out_data;

  modport master (
    output in_valid, in_data, in_first, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_first, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/sha1_word_buf.sv
// Message block buffer: written one 32-bit word per accept, read one bit per cycle
// as the serial W stream for rounds 0..N_WORDS-1 (LSB first), zero afterwards.
module sha1_word_buf
  import sha1_pkg::*;
#(
  parameter int N_WORDS = DEF_N_WORDS
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [$clog2(N_WORDS)-1:0] wr_idx,
  input  logic [WORD_W-1:0]          wr_data,
  input  logic [ROUND_W-1:0]         rd_round,
  input  logic [STEP_W-1:0]          rd_step,
  output logic                       w_bit
);

  localparam logic [ROUND_W-1:0] RND_W_LAST = ROUND_W'(N_WORDS - 1);

  logic [WORD_W-1:0] mem [N_WORDS];

  // Pure storage: contents are always rewritten before they are read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_comb begin
    w_bit = 1'b0;
    if (rd_round <= RND_W_LAST) begin
      w_bit = mem[rd_round[$clog2(N_WORDS)-1:0]][rd_step];
    end
  end

endmodule

// File: rtl/sha1_sequencer.sv
// Control side of the bit-serial SHA-1 core: loads a 16-word block, drives round/step
// and the serial W/chaining streams, and collects the serial digest into a 160-bit result.
module sha1_sequencer
  import sha1_pkg::*;
#(
  parameter int N_WORDS    = DEF_N_WORDS,
  parameter int OUT_BASE   = DEF_OUT_BASE,
  parameter int IDLE_ROUND = DEF_IDLE_ROUND
) (
  input  logic               clk,
  input  logic               rst_n,
  sha1_sequencer_if.slave    host,
  output logic [ROUND_W-1:0] round,
  output logic [STEP_W-1:0]  step,
  output logic               w_out,
  output logic               a_out,
  input  logic               init_in,
  input  logic               h_in
);

  localparam int CNT_W = $clog2(N_WORDS);
  localparam logic [CNT_W-1:0]   CNT_LAST        = CNT_W'(N_WORDS - 1);
  localparam logic [ROUND_W-1:0] RND_IDLE        = ROUND_W'(IDLE_ROUND);
  localparam logic [ROUND_W-1:0] RND_OUT_FIRST   = ROUND_W'(OUT_BASE);
  localparam logic [ROUND_W-1:0] RND_OUT_LAST    = ROUND_W'(OUT_BASE + 4);
  localparam logic [ROUND_W-1:0] RND_CHAIN_FIRST = ROUND_W'(CHAIN_FIRST);
  localparam logic [ROUND_W-1:0] RND_CHAIN_LAST  = ROUND_W'(CHAIN_LAST);
  localparam logic [STEP_W-1:0]  STEP_LAST       = STEP_W'(31);

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     count;
  logic                 first_q;
  logic [ROUND_W-1:0]   round_q;
  logic [STEP_W-1:0]    step_q;
  logic [DIGEST_W-1:0]  digest;

  logic                 accept;
  logic                 run_last;
  logic                 in_chain;
  logic                 in_capture;
  logic [2:0]           chain_rel;
  logic [2:0]           cap_rel;
  logic [7:0]           chain_idx;
  logic [7:0]           cap_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    run_last  = 1'b0;
    case (state)
      LOAD: begin
        accept = host.in_valid;
        if (accept && (count == CNT_LAST)) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        run_last = (round_q == RND_OUT_LAST) && (step_q == STEP_LAST);
        if (run_last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (host.out_ready) begin
          state_nxt = LOAD;
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  assign host.in_ready  = (state == LOAD);
  assign host.out_valid = (state == DONE);
  assign host.out_data  = digest;
  assign round          = round_q;
  assign step           = step_q;

  // in_first is only meaningful on word 0; later words may carry anything there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      first_q <= 1'b1;
      round_q <= RND_IDLE;
      step_q  <= '0;
    end else begin
      if (accept) begin
        count <= (count == CNT_LAST) ? '0 : count + 1'b1;
        if (count == '0) begin
          first_q <= host.in_first;
        end
      end
      if ((state == LOAD) && (state_nxt == RUN)) begin
        round_q <= '0;
        step_q  <= '0;
      end else if (state == RUN) begin
        if (run_last) begin
          round_q <= RND_IDLE;
          step_q  <= '0;
        end else begin
          step_q <= step_q + 1'b1;
          if (step_q == STEP_LAST) begin
            round_q <= round_q + 1'b1;
          end
        end
      end
    end
  end

  // Digest word H0 sits at the top of out_data, so round OUT_BASE+k lands in word 4-k.
  assign in_capture = (state == RUN) && (round_q >= RND_OUT_FIRST) && (round_q <= RND_OUT_LAST);
  assign cap_rel    = 3'(RND_OUT_LAST - round_q);
  assign cap_idx    = {cap_rel, step_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digest <= '0;
    end else if (in_capture) begin
      digest[cap_idx] <= h_in;
    end
  end

  // Chaining feed runs H4 first (round 11) up to H0 (round 15), i.e. the low word of out_data first.
  assign in_chain  = (state == RUN) && (round_q >= RND_CHAIN_FIRST) && (round_q <= RND_CHAIN_LAST);
  assign chain_rel = 3'(round_q - RND_CHAIN_FIRST);
  assign chain_idx = {chain_rel, step_q};

  always_comb begin
    a_out = 1'b0;
    if (in_chain) begin
      a_out = first_q ? init_in : digest[chain_idx];
    end
  end

  sha1_word_buf #(
    .N_WORDS (N_WORDS)
  ) u_word_buf (
    .clk      (clk),
    .wr_en    (accept),
    .wr_idx   (count),
    .wr_data  (host.in_data),
    .rd_round (round_q),
    .rd_step  (step_q),
    .w_bit    (w_out)
  );

endmodule

// File: tb/tb_sha1_sequencer.sv
// Directed bench for sha1_sequencer with a behavioural bit-serial SHA-1 core that
// rebuilds W and the chaining value from the serial streams and returns the digest on h_in.
module tb_sha1_sequencer;
  import sha1_pkg::*;

  localparam logic [159:0] ABC_DIG = 160'hA9993E36_4706816A_BA3E2571_7850C26C_9CD0D89D;
  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK2 = {
    32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F,
    32'h10111213, 32'h14151617, 32'h18191A1B, 32'h1C1D1E1F,
    32'hDEADBEEF, 32'h80000001, 32'hFFFFFFFF, 32'h00000000,
    32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 32'hF0F0F0F0};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] round;
  logic [4:0] step;
  logic       w_out, a_out, init_in, h_in;

  sha1_sequencer_if ifc ();

  sha1_sequencer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .host    (ifc),
    .round   (round),
    .step    (step),
    .w_out   (w_out),
    .a_out   (a_out),
    .init_in (init_in),
    .h_in    (h_in)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [159:0] model_dig = '0;
  logic [31:0]  wcol [16];
  logic [31:0]  acol [5];
  logic [511:0] cblk;
  int           w_err = 0;
  int           seq_err = 0;
  logic         w16 = 1'b1;
  logic [6:0]   prev_r = '0;
  logic [4:0]   prev_s = '0;
  bit           prev_ok = 1'b0;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [159:0] sha1_compress(input logic [511:0] blk, input logic [159:0] hv);
    logic [31:0] w [80];
    logic [31:0] a, b, c, d, e, f, k, t;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 80; i++) w[i] = rotl(w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16], 1);
    a = hv[159:128]; b = hv[127:96]; c = hv[95:64]; d = hv[63:32]; e = hv[31:0];
    for (int i = 0; i < 80; i++) begin
      if (i < 20) begin
        f = (b & c) | (~b & d); k = 32'h5A827999;
      end else if (i < 40) begin
        f = b ^ c ^ d;          k = 32'h6ED9EBA1;
      end else if (i < 60) begin
        f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC;
      end else begin
        f = b ^ c ^ d;          k = 32'hCA62C1D6;
      end
      t = rotl(a, 5) + f + e + k + w[i];
      e = d; d = c; c = rotl(b, 30); b = a; a = t;
    end
    return {hv[159:128] + a, hv[127:96] + b, hv[95:64] + c, hv[63:32] + d, hv[31:0] + e};
  endfunction

  // Core side: IV bits in rounds 11..15 (H4 first), digest bits in rounds 80..84 (H0 first).
  always_comb begin
    init_in = 1'b0;
    h_in    = 1'b0;
    if (round >= 7'd11 && round <= 7'd15)
      init_in = IV[8'(32 * (int'(round) - 11) + int'(step))];
    if (round >= 7'd80 && round <= 7'd84)
      h_in = model_dig[8'(32 * (84 - int'(round)) + int'(step))];
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ok = 1'b0;
    end else begin
      if (prev_ok) begin
        if (prev_s == 5'd31) begin
          if (prev_r == 7'd84) begin
            if (round !== 7'd127 || step !== 5'd0) seq_err++;
          end else if (round !== prev_r + 7'd1 || step !== 5'd0) seq_err++;
        end else if (round !== prev_r || step !== prev_s + 5'd1) seq_err++;
      end
      if (round <= 7'd84) begin
        if (round <= 7'd15) wcol[round[3:0]][step] = w_out;
        else if (w_out !== 1'b0) w_err++;
        if (round >= 7'd11 && round <= 7'd15) acol[int'(round) - 11][step] = a_out;
        if (round == 7'd16 && step == 5'd0) begin
          w16 = w_out;
          for (int i = 0; i < 16; i++) cblk[511-32*i -: 32] = wcol[i];
          model_dig = sha1_compress(cblk, {acol[4], acol[3], acol[2], acol[1], acol[0]});
        end
        prev_ok = 1'b1;
        prev_r  = round;
        prev_s  = step;
      end else begin
        prev_ok = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_block(input logic [511:0] blk, input logic first, input int gap);
    for (int i = 0; i < 16; i++) begin
      repeat (gap) begin
        ifc.in_valid = 1'b0;
        ifc.in_data  = $urandom;
        @(posedge clk); #1;
      end
      ifc.in_valid = 1'b1;
      ifc.in_data  = blk[511-32*i -: 32];
      ifc.in_first = (i == 0) ? first : ~first;
      @(posedge clk); #1;
      ifc.in_valid = 1'b0;
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!ifc.out_valid && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic handshake(input string tag);
    ifc.out_ready = 1'b1;
    @(posedge clk); #1;
    ifc.out_ready = 1'b0;
    chk({tag, "_out_valid_cleared"}, 160'(ifc.out_valid), 160'(1'b0));
    chk({tag, "_in_ready_back"}, 160'(ifc.in_ready), 160'(1'b1));
  endtask

  initial begin
    int           cyc;
    bit           stable;
    bit           found;
    logic [159:0] exp2;

    ifc.in_valid  = 1'b0;
    ifc.in_data   = '0;
    ifc.in_first  = 1'b0;
    ifc.out_ready = 1'b0;
    rst_n         = 1'b0;

    repeat (3) @(posedge clk); #1;
    chk("rst_in_ready",  160'(ifc.in_ready),  160'(1'b1));
    chk("rst_out_valid", 160'(ifc.out_valid), 160'(1'b0));
    chk("rst_round",     160'(round),         160'(7'd127));
    chk("rst_step",      160'(step),          160'(5'd0));
    chk("rst_out_data",  ifc.out_data,        160'h0);
    chk("rst_w_out",     160'(w_out),         160'(1'b0));
    chk("rst_a_out",     160'(a_out),         160'(1'b0));
    rst_n = 1'b1;
    repeat (10) @(posedge clk); #1;
    chk("idle_in_ready",  160'(ifc.in_ready),  160'(1'b1));
    chk("idle_out_valid", 160'(ifc.out_valid), 160'(1'b0));
    chk("idle_round",     160'(round),         160'(7'd127));
    chk("idle_step",      160'(step),          160'(5'd0));
    chk("idle_out_data",  ifc.out_data,        160'h0);

    // Block 1: "abc", first block
    send_block(ABC_BLK, 1'b1, 0);
    wait_done(cyc);
    chk("b1_run_len",      160'(cyc),            160'(2720));
    chk("b1_done_round",   160'(round),          160'(7'd127));
    chk("b1_done_in_rdy",  160'(ifc.in_ready),   160'(1'b0));
    chk("b1_w0_stream",    160'(wcol[0]),        160'(32'h61626380));
    chk("b1_w15_stream",   160'(wcol[15]),       160'(32'h00000018));
    chk("b1_a_r11_iv",     160'(acol[0]),        160'(IV_H4));
    chk("b1_a_r15_iv",     160'(acol[4]),        160'(IV_H0));
    chk("b1_w_r16_s0",     160'(w16),            160'(1'b0));
    chk("b1_w_late_zero",  160'(w_err),          160'(0));
    chk("b1_round_seq",    160'(seq_err),        160'(0));
    chk("b1_digest",       ifc.out_data,         ABC_DIG);
    handshake("b1");

    // Block 2: chained, 1-of-3 input valid, output backpressure
    exp2 = sha1_compress(BLK2, ABC_DIG);
    send_block(BLK2, 1'b0, 2);
    wait_done(cyc);
    chk("b2_run_len",      160'(cyc),            160'(2720));
    chk("b2_a_r11_chain",  160'(acol[0]),        160'(32'h9CD0D89D));
    chk("b2_a_r15_chain",  160'(acol[4]),        160'(32'hA9993E36));
    for (int i = 0; i < 16; i++)
      chk($sformatf("b2_word%0d", i), 160'(wcol[i]), 160'(BLK2[511-32*i -: 32]));
    chk("b2_digest",       ifc.out_data,         exp2);
    stable = 1'b1;
    repeat (50) begin
      @(posedge clk); #1;
      if (ifc.out_data !== exp2 || ifc.out_valid !== 1'b1 || ifc.in_ready !== 1'b0 || round !== 7'd127)
        stable = 1'b0;
    end
    chk("b2_hold_stable",  160'(stable),         160'(1'b1));
    chk("b2_round_seq",    160'(seq_err),        160'(0));
    handshake("b2");

    // Block 3: reset at round 40 step 7
    send_block(ABC_BLK, 1'b0, 0);
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      if (round == 7'd40 && step == 5'd7) found = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("b3_reached_r40s7", 160'(found), 160'(1'b1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_round",     160'(round),         160'(7'd127));
    chk("mid_rst_step",      160'(step),          160'(5'd0));
    chk("mid_rst_in_ready",  160'(ifc.in_ready),  160'(1'b1));
    chk("mid_rst_out_valid", 160'(ifc.out_valid), 160'(1'b0));
    chk("mid_rst_out_data",  ifc.out_data,        160'h0);
    chk("mid_rst_w_out",     160'(w_out),         160'(1'b0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Block 4: fresh "abc" after reset
    send_block(ABC_BLK, 1'b1, 0);
    wait_done(cyc);
    chk("b4_run_len",     160'(cyc),       160'(2720));
    chk("b4_digest",      ifc.out_data,    ABC_DIG);
    chk("b4_w_late_zero", 160'(w_err),     160'(0));
    chk("b4_round_seq",   160'(seq_err),   160'(0));
    handshake("b4");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sha1_sequencer.md
Name: sha1_sequencer

Overview:
Control-side counterpart of the bit-serial SHA-1 round core. Accepts one 512-bit message block as 16 parallel 32-bit words over a valid/ready handshake. Drives the core's round/step counters, the serial W stream and the serial chaining-value stream. Captures the serial digest the core returns and presents it as a parallel 160-bit result over a second valid/ready handshake. Sits between the TOTP HMAC controller (word source and digest sink) and the round core.

Parameters:
N_WORDS, 16, message words buffered per block
OUT_BASE, 80, first digest-output round (rounds OUT_BASE..OUT_BASE+4 carry H0..H4)
IDLE_ROUND, 127, value driven on round outside RUN

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_data/in_first valid
in_ready  output  1  sequencer accepts a word this cycle
in_data  input  32  message word, W0 first (big-endian SHA-1 word order)
in_first  input  1  sampled with word 0 only: 1 = first block (use IV), 0 = chain from held digest
round  output  7  round index to core
step  output  5  bit index within round, 0..31
w_out  output  1  serial W bit to core (core w_in)
a_out  output  1  serial chaining bit to core (core a_in)
init_in  input  1  core's serial IV constant bit (core init_out)
h_in  input  1  serial digest bit from core (core h_out)
out_valid  output  1  digest valid
out_ready  input  1  digest consumer ready
out_data  output  160  digest {H0,H1,H2,H3,H4}, H0 in [159:128]

Behaviour:
- Decided: one clock, clk. Reset rst_n is asynchronous and active-low.
- States: LOAD, RUN, DONE. Reset → LOAD, word count 0, round=IDLE_ROUND, step=0, in_ready=1, out_valid=0, out_data=0, w_out=0, a_out=0, first flag=1.
- LOAD: in_ready=1. On in_valid&in_ready, store in_data to buf[count] and increment count. When count=0, also latch in_first. Accepting word 15 moves to RUN on the next cycle with round=0, step=0.
- RUN: step increments every cycle. When step=31, step wraps to 0 and round increments. When round=OUT_BASE+4 and step=31, go to DONE. RUN lasts exactly 85*32 = 2720 cycles. in_ready=0.
- w_out: buf[round][step] for round 0..15 (LSB first), else 0.
- a_out: only for round 11..15, else 0.
  - first flag set: a_out = init_in (combinational pass-through).
  - first flag clear: a_out = digest word (round-11), bit step, taken from out_data. Word order: round 11→H4, 12→H3, 13→H2, 14→H1, 15→H0, i.e. out_data[32*(round-11)+step].
- w_out and a_out are combinational only from registered state, plus init_in. There is no path from in_* to any output.
- Capture: in rounds OUT_BASE..OUT_BASE+4, h_in is shifted into digest word Hk, k = round-OUT_BASE, bit step (LSB first). out_data is not updated outside these rounds.
- DONE: out_valid=1, round=IDLE_ROUND, out_data stable. On out_valid&out_ready, go to LOAD next cycle: count=0, out_valid=0. out_data is retained as the chaining value.
- in_ready is 0 in RUN and DONE, so input and output handshakes never overlap.
- in_valid held low in LOAD: wait indefinitely. Partial word count is kept.
- Reset asserted mid-RUN or mid-DONE: immediate return to reset values. The digest is lost, so the next block must set in_first=1. Chaining across reset is undefined.
- Counter width: round never exceeds OUT_BASE+4 in RUN. IDLE_ROUND decodes as a final-phase round in the core; this is harmless because w_out=a_out=0.

Decomposition:
- Shared sha1_pkg:
  - state enum {LOAD, RUN, DONE}
  - constants for round boundaries: W_LAST=15, CHAIN_FIRST=11, CHAIN_LAST=15, OUT_BASE=80, IDLE_ROUND=127
  - SHA-1 IV constants, for benches
- One natural sub-module, sha1_word_buf: 16x32 write-by-index / read-by-bit buffer with w_out bit mux.

Test Plan:
- Reset: rst_n low → in_ready=1, out_valid=0, round=127, step=0, out_data=0. Release, idle 10 cycles → no change.
- "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018, in_first=1), bench core model driving h_in:
  - round 0 steps 0..31 w_out = 0x61626380 LSB-first.
  - a_out == init_in in rounds 11..15.
  - out_valid exactly 2720 cycles after RUN entry.
  - out_data = A9993E36_4706816A_BA3E2571_7850C26C_9CD0D89D.
- Chaining: second block with in_first=0 → a_out in round 11 streams 0x9CD0D89D, in round 15 streams 0xA9993E36, LSB-first.
- Backpressure: in_valid toggled 1-of-3 during LOAD; out_ready held low 50 cycles in DONE → words stored in order, out_data stable, no re-entry to LOAD until the handshake.
- Mid-run reset: rst_n pulsed low at round 40 step 7 → outputs at reset values immediately; a fresh "abc" block then yields the correct digest.
- Boundary: step 31→0 transitions at rounds 15→16 and 84→DONE → w_out=0 from round 16 step 0; round=127 on the first DONE cycle.
